// File: rtl/power_detect_pkg.sv
// Shared types and helpers for the power detector.
package power_detect_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    DETECT = 2'd2
  } pd_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/power_detect_mag_delay_line.sv
// Circular sample history: presents the sample written N writes ago at the
// current pointer, then overwrites it on a write.
module mag_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LOG2   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] oldest_o
);

  localparam int NWIN = 1 << WIN_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [NWIN];
  logic [WIN_LOG2-1:0]   ptr_q;

  // Oldest sample sits at the slot about to be overwritten.
  assign oldest_o = mem_q[ptr_q];

  // Storage is deliberately not reset; the caller masks it until refilled.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[ptr_q] <= din_i;
  end

  // Write pointer, wraps naturally modulo N.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ptr_q <= '0;
    else if (wr_en_i) ptr_q <= ptr_q + 1'b1;
  end

endmodule

// File: rtl/power_detect.sv
// Moving-average power detector with hysteretic trigger.
module power_detect
  import power_detect_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LOG2   = 4,
  parameter int HOLD_ON    = 4,
  parameter int HOLD_OFF   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] mag,
  input  logic                  mag_stb,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic [DATA_WIDTH-1:0] avg_mag,
  output logic                  avg_stb,
  output logic                  trigger,
  output logic                  trigger_stb
);

  localparam int NWIN  = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_WIDTH + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_LAST = (WIN_LOG2+1)'(NWIN - 1);
  localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2+1)'(NWIN);

  logic                  accept;
  logic                  full;
  logic                  last_or_full;
  logic [DATA_WIDTH-1:0] oldest_raw;
  logic [DATA_WIDTH-1:0] oldest;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [WIN_LOG2:0]     fill_q, fill_d;
  logic [DATA_WIDTH-1:0] avg_mag_q;
  logic                  avg_stb_q;

  pd_state_e             state_q, state_d;
  logic [CNT_W-1:0]      on_q, on_d, off_q, off_d;
  logic [CNT_W-1:0]      on_inc, off_inc;
  logic                  trig_q, trig_d;
  logic                  tstb_q, tstb_d;
  logic                  eval;
  logic                  qual;

  assign accept       = enable & mag_stb;
  assign full         = (fill_q == FILL_FULL);
  assign last_or_full = (fill_q >= FILL_LAST);

  mag_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIN_LOG2   (WIN_LOG2)
  ) u_hist (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en_i  (accept),
    .din_i    (mag),
    .oldest_o (oldest_raw)
  );

  // Until the window has been filled since reset, history slots are stale.
  assign oldest = full ? oldest_raw : '0;
  assign sum_d  = sum_q + SUM_W'(mag) - SUM_W'(oldest);
  assign fill_d = full ? fill_q : fill_q + 1'b1;

  // Running sum, fill count and registered average; frozen when disabled.
  // A pending avg strobe is held across disabled cycles and shown on resume.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q     <= '0;
      fill_q    <= '0;
      avg_mag_q <= '0;
      avg_stb_q <= 1'b0;
    end else if (enable) begin
      avg_stb_q <= accept & last_or_full;
      if (accept) begin
        sum_q  <= sum_d;
        fill_q <= fill_d;
        if (last_or_full) avg_mag_q <= sum_d[SUM_W-1:WIN_LOG2];
      end
    end
  end

  assign eval    = enable & avg_stb_q;
  assign qual    = (avg_mag_q >= threshold);
  assign on_inc  = sat_inc(on_q);
  assign off_inc = sat_inc(off_q);

  // Detector state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      on_q    <= '0;
      off_q   <= '0;
      trig_q  <= 1'b0;
      tstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      off_q   <= off_d;
      trig_q  <= trig_d;
      tstb_q  <= tstb_d;
    end
  end

  // Hysteresis: HOLD_ON qualifying averages in a row to assert,
  // HOLD_OFF non-qualifying in a row to release.
  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    off_d   = off_q;
    trig_d  = trig_q;
    tstb_d  = enable ? 1'b0 : tstb_q;
    case (state_q)
      FILL: begin
        if (accept && fill_q == FILL_LAST) state_d = SEARCH;
      end
      SEARCH: begin
        if (eval) begin
          if (!qual) begin
            on_d = '0;
          end else if (on_inc >= CNT_W'(HOLD_ON)) begin
            state_d = DETECT;
            trig_d  = 1'b1;
            tstb_d  = 1'b1;
            on_d    = '0;
          end else begin
            on_d = on_inc;
          end
        end
      end
      DETECT: begin
        if (eval) begin
          if (qual) begin
            off_d = '0;
          end else if (off_inc >= CNT_W'(HOLD_OFF)) begin
            state_d = SEARCH;
            trig_d  = 1'b0;
            off_d   = '0;
          end else begin
            off_d = off_inc;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign avg_mag     = avg_mag_q;
  assign avg_stb     = avg_stb_q & enable;
  assign trigger     = trig_q;
  assign trigger_stb = tstb_q & enable;

endmodule

// File: tb/tb_power_detect.sv
// Scoreboard bench for power_detect: stimulus pushes expected averages and
// expected trigger edges (by average index since reset); a monitor compares.
module tb_power_detect;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] mag;
  logic        mag_stb;
  logic [15:0] threshold;
  logic [15:0] avg_mag;
  logic        avg_stb;
  logic        trigger;
  logic        trigger_stb;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_avg_q [$];
  int          exp_rise_q [$];
  int          exp_fall_q [$];

  int win [$];
  int acc_cnt = 0;

  power_detect #(
    .DATA_WIDTH (16),
    .WIN_LOG2   (4),
    .HOLD_ON    (4),
    .HOLD_OFF   (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .mag         (mag),
    .mag_stb     (mag_stb),
    .threshold   (threshold),
    .avg_mag     (avg_mag),
    .avg_stb     (avg_stb),
    .trigger     (trigger),
    .trigger_stb (trigger_stb)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Window model: expected average of the last 16 accepted samples.
  task automatic model_push(input logic [15:0] m);
    longint s;
    win.push_back(int'(m));
    if (win.size() > 16) void'(win.pop_front());
    acc_cnt++;
    if (acc_cnt >= 16) begin
      s = 0;
      foreach (win[i]) s += win[i];
      exp_avg_q.push_back(16'(s / 16));
    end
  endtask

  task automatic model_reset();
    win.delete();
    acc_cnt = 0;
  endtask

  task automatic step(input logic [15:0] m, input logic stb, input logic en);
    mag = m; mag_stb = stb; enable = en;
    if (stb && en) model_push(m);
    @(posedge clock); #1;
  endtask

  // Monitor: trigger edges are keyed to the number of averages seen before
  // the current cycle; averages are popped from the scoreboard.
  int  avg_idx   = 0;
  logic prev_trig = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      avg_idx   = 0;
      prev_trig = 1'b0;
    end else begin
      if (trigger_stb) begin
        if (exp_rise_q.size() == 0) chk("unexpected_trigger_stb", avg_idx, 32'hFFFF_FFFF);
        else begin
          chk("trigger_rise_idx", avg_idx, exp_rise_q.pop_front());
          chk("trigger_level_on_stb", trigger, 1);
        end
      end
      if (prev_trig && !trigger) begin
        if (exp_fall_q.size() == 0) chk("unexpected_trigger_fall", avg_idx, 32'hFFFF_FFFF);
        else chk("trigger_fall_idx", avg_idx, exp_fall_q.pop_front());
      end
      prev_trig = trigger;
      if (avg_stb) begin
        avg_idx++;
        if (exp_avg_q.size() == 0) chk("unexpected_avg_stb", avg_mag, 32'hFFFF_FFFF);
        else chk("avg_mag", avg_mag, exp_avg_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; mag = '0; mag_stb = 1'b0; threshold = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_avg_mag", avg_mag, 0);
    chk("rst_avg_stb", avg_stb, 0);
    chk("rst_trigger", trigger, 0);
    chk("rst_trigger_stb", trigger_stb, 0);
    reset_n = 1'b1;

    // Constant 100 vs threshold 50: avg#1 at sample 16, trigger after avg#4.
    threshold = 16'd50;
    exp_rise_q.push_back(4);
    for (int i = 0; i < 24; i++) step(16'd100, 1'b1, 1'b1);

    // 32s then zeros with threshold 20: 7th zero (avg 18) starts the release
    // count, 22nd zero is the 16th non-qualifying average (avg#47).
    threshold = 16'd20;
    for (int i = 0; i < 16; i++) step(16'd32, 1'b1, 1'b1);
    exp_fall_q.push_back(47);
    for (int i = 0; i < 24; i++) step(16'd0, 1'b1, 1'b1);
    chk("trigger_after_release", trigger, 0);

    // Averages of 0 with threshold toggled so evaluations run 3 qualify,
    // 1 not: never four in a row, so no trigger.
    for (int i = 0; i < 16; i++) begin
      threshold = (i % 4 == 3) ? 16'd1 : 16'd0;
      step(16'd0, 1'b1, 1'b1);
    end
    threshold = 16'd1;
    step(16'd0, 1'b0, 1'b1);
    chk("trigger_oscillating", trigger, 0);

    // Strobe every cycle, enable toggling: only enabled samples count.
    threshold = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      step(16'(i * 10 + 5), 1'b1, 1'b1);
      step(16'h7777, 1'b1, 1'b0);
    end
    step(16'd0, 1'b0, 1'b1);
    step(16'd0, 1'b0, 1'b1);

    // Full-scale input, then async reset mid-stream.
    reset_n = 1'b0; model_reset();
    step(16'd0, 1'b0, 1'b1);
    step(16'd0, 1'b0, 1'b1);
    reset_n = 1'b1;
    exp_rise_q.push_back(4);
    for (int i = 0; i < 19; i++) step(16'hFFFF, 1'b1, 1'b1);
    step(16'd0, 1'b0, 1'b1);
    step(16'd0, 1'b0, 1'b1);
    chk("max_avg_hold", avg_mag, 16'hFFFF);
    chk("max_trigger", trigger, 1);
    reset_n = 1'b0; model_reset();
    #1;
    chk("async_rst_avg_mag", avg_mag, 0);
    chk("async_rst_trigger", trigger, 0);
    chk("async_rst_avg_stb", avg_stb, 0);
    chk("async_rst_trigger_stb", trigger_stb, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) step(16'h0010, 1'b1, 1'b1);
    repeat (3) step(16'd0, 1'b0, 1'b1);
    chk("post_rst_avg_mag", avg_mag, 16'h0010);

    chk("avg_queue_drained", exp_avg_q.size(), 0);
    chk("rise_queue_drained", exp_rise_q.size(), 0);
    chk("fall_queue_drained", exp_fall_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
